bus_timer: RTL and testbench
============================

Name: bus_timer

Overview:
- Memory-mapped 16-bit timer/counter that acts as a responder on the CPU data bus (Addr, Dout, write, read, Din).
- Provides a prescaler, a compare/match event and an interrupt request line for one of the CPU's 8 interrupt inputs.
- Sits beside the RAM and I/O responders; its read data is zero when not selected, so all responders' outputs OR together onto the CPU Din.

Parameters:
- BASE_ADDR, 16'hFF00, base of the 4-word register window; must be 4-word aligned (bits [1:0] = 0).
- RST_COMPARE, 16'hFFFF, reset value of the COMPARE register.

Ports:
- clk_bus  input  1  system clock; all state changes on the rising edge.
- rst_bus  input  1  synchronous, active-high reset.
- addr  input  16  bus address from the CPU (CPU Addr).
- wdata  input  16  bus write data (CPU Dout).
- write  input  1  write strobe, one cycle per access.
- read  input  1  read strobe.
- rdata  output  16  read data toward the CPU Din; 0 when not selected.
- irq  output  1  level interrupt = CTRL.MATCH & CTRL.IE.
- irq_pulse  output  1  one-cycle pulse on the cycle after a match event, when IE=1.

Behaviour:
- Reset and clock domain: one clock (clk_bus); reset is synchronous and active-high on rst_bus. On reset: CTRL=0, PRESCALE=0, COMPARE=RST_COMPARE, COUNT=0, prescale counter pcnt=0, irq=0, irq_pulse=0.
- Select: sel = (addr[15:2] == BASE_ADDR[15:2]); offset = addr[1:0].
- Register map:
  - 0 CTRL: bit0 EN, bit1 AUTO (auto-reload), bit2 IE, bit8 MATCH (sticky; write 1 to clear). Other bits read 0, writes to them are ignored.
  - 1 PRESCALE: one tick every PRESCALE+1 enabled cycles.
  - 2 COMPARE: terminal count.
  - 3 COUNT: reads the live count. A write loads the count and clears pcnt.
- Reads: rdata is combinational. rdata = register[offset] when read & sel, else 16'h0000. With read and write in the same cycle, rdata shows the pre-write value.
- Writes: take effect at the clock edge on which write & sel is sampled. Writing CTRL with EN going 0→1 clears pcnt.
- Counting (only when EN=1 at the start of the cycle):
  - If pcnt == PRESCALE: pcnt ← 0 and a tick occurs. Otherwise pcnt ← pcnt+1.
  - On a tick with COUNT == COMPARE: MATCH ← 1, COUNT ← 0; if AUTO=0 then EN ← 0 (one-shot).
  - On a tick otherwise: COUNT ← COUNT+1, 16-bit wrap (only possible if COMPARE < COUNT after a software write).
  - Period = (COMPARE+1)·(PRESCALE+1) cycles.
  - PRESCALE=0 gives a tick every cycle. COMPARE=0 gives a match on every tick.
- EN=0: pcnt and COUNT hold.
- irq_pulse is registered: high for exactly one cycle after the edge that set MATCH from a match event, if IE=1. It fires on every match event, even if MATCH was already set.
- Simultaneous events:
  - Bus write to COUNT and a tick on the same edge: the write wins; no match is evaluated.
  - W1C of MATCH and a new match on the same edge: MATCH stays 1 (set wins).
  - Write to CTRL clearing EN and a tick on the same edge: the write wins for EN; the tick's COUNT/MATCH update still applies.
  - One-shot match and a write setting EN=1 on the same edge: EN=1.
- Reset asserted mid-count: all state returns to reset values on that edge; irq drops on the next cycle.

Test Plan:
- Reset then read all four offsets at BASE_ADDR+0..3 → 0x0000, 0x0000, 0xFFFF, 0x0000; irq=0. A read at BASE_ADDR+4 → 0x0000.
- Auto-reload run: PRESCALE=3, COMPARE=4, then write CTRL=0x0007 at edge E0.
  - COUNT reads 1 after E4, 4 after E16.
  - MATCH=1, COUNT=0 and irq=1 after E20; irq_pulse high for exactly the cycle after E20.
  - Next irq_pulse after E40.
- One-shot: PRESCALE=0, COMPARE=2, CTRL=0x0001.
  - MATCH set after the 3rd edge, CTRL reads 0x0100 (EN cleared).
  - COUNT stays 0 for 10 further cycles; irq=0 because IE=0.
- W1C: with MATCH=1 and IE=1, write CTRL=0x0105 → CTRL reads 0x0005 and irq=0 the next cycle.
  - Repeat with the write aligned to a match edge → MATCH stays 1.
- COUNT write vs tick: PRESCALE=0, COMPARE=100, running; write COUNT=0x0050 on an edge → COUNT reads 0x0050 (no +1), then 0x0051 on the next edge.
- Reset mid-operation: assert rst_bus for one cycle while COUNT=3 and irq=1 → all registers at reset values and irq=0 after that edge; a write to CTRL with rst_bus=1 is ignored.

Source files
------------

// File: rtl/bus_timer.sv
// bus_timer: memory-mapped 16-bit timer/counter responder on the CPU data bus.
// Four-word window (CTRL, PRESCALE, COMPARE, COUNT), prescaler, compare match
// with sticky MATCH flag, level irq and a one-cycle irq_pulse per match event.
module bus_timer #(
    parameter logic [15:0] BASE_ADDR   = 16'hFF00,
    parameter logic [15:0] RST_COMPARE = 16'hFFFF
) (
    input  logic        clk_bus,
    input  logic        rst_bus,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    input  logic        write,
    input  logic        read,
    output logic [15:0] rdata,
    output logic        irq,
    output logic        irq_pulse
);

    localparam logic [1:0] OFF_CTRL     = 2'd0;
    localparam logic [1:0] OFF_PRESCALE = 2'd1;
    localparam logic [1:0] OFF_COMPARE  = 2'd2;
    localparam logic [1:0] OFF_COUNT    = 2'd3;

    logic        en_q, en_d;
    logic        auto_q, auto_d;
    logic        ie_q, ie_d;
    logic        match_q, match_d;
    logic [15:0] prescale_q, prescale_d;
    logic [15:0] compare_q, compare_d;
    logic [15:0] count_q, count_d;
    logic [15:0] pcnt_q, pcnt_d;
    logic        irq_pulse_q, irq_pulse_d;

    logic        sel;
    logic [1:0]  offset;
    logic        wr_ctrl, wr_prescale, wr_compare, wr_count;
    logic        tick;
    logic        match_evt;

    assign sel    = (addr[15:2] == BASE_ADDR[15:2]);
    assign offset = addr[1:0];

    assign wr_ctrl     = write && sel && (offset == OFF_CTRL);
    assign wr_prescale = write && sel && (offset == OFF_PRESCALE);
    assign wr_compare  = write && sel && (offset == OFF_COMPARE);
    assign wr_count    = write && sel && (offset == OFF_COUNT);

    // A tick needs EN at the start of the cycle; a COUNT write suppresses the
    // match since the loaded value replaces whatever the tick would produce.
    assign tick      = en_q && (pcnt_q == prescale_q);
    assign match_evt = tick && (count_q == compare_q) && !wr_count;

    assign irq       = match_q && ie_q;
    assign irq_pulse = irq_pulse_q;

    // Combinational read mux; zero when unselected so responders can be OR'd.
    always_comb begin
        rdata = 16'h0000;
        if (read && sel) begin
            case (offset)
                OFF_CTRL:     rdata = {7'b0, match_q, 5'b0, ie_q, auto_q, en_q};
                OFF_PRESCALE: rdata = prescale_q;
                OFF_COMPARE:  rdata = compare_q;
                default:      rdata = count_q;
            endcase
        end
    end

    // Next-state: counting first, then bus writes layered on top (write wins).
    always_comb begin
        en_d        = en_q;
        auto_d      = auto_q;
        ie_d        = ie_q;
        match_d     = match_q;
        prescale_d  = prescale_q;
        compare_d   = compare_q;
        count_d     = count_q;
        pcnt_d      = pcnt_q;
        irq_pulse_d = match_evt && ie_q;

        if (en_q) begin
            if (tick) begin
                pcnt_d = 16'h0000;
                if (count_q == compare_q) begin
                    count_d = 16'h0000;
                    if (!auto_q) en_d = 1'b0;
                end else begin
                    count_d = count_q + 16'h0001;
                end
            end else begin
                pcnt_d = pcnt_q + 16'h0001;
            end
        end

        if (wr_ctrl) begin
            en_d   = wdata[0];
            auto_d = wdata[1];
            ie_d   = wdata[2];
            if (wdata[8]) match_d = 1'b0;
            // Starting the timer always begins a fresh prescale period.
            if (!en_q && wdata[0]) pcnt_d = 16'h0000;
        end
        if (wr_prescale) prescale_d = wdata;
        if (wr_compare)  compare_d  = wdata;
        if (wr_count) begin
            count_d = wdata;
            pcnt_d  = 16'h0000;
        end

        // A new match beats a simultaneous write-1-to-clear.
        if (match_evt) match_d = 1'b1;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_bus) begin
        if (rst_bus) begin
            en_q        <= 1'b0;
            auto_q      <= 1'b0;
            ie_q        <= 1'b0;
            match_q     <= 1'b0;
            prescale_q  <= 16'h0000;
            compare_q   <= RST_COMPARE;
            count_q     <= 16'h0000;
            pcnt_q      <= 16'h0000;
            irq_pulse_q <= 1'b0;
        end else begin
            en_q        <= en_d;
            auto_q      <= auto_d;
            ie_q        <= ie_d;
            match_q     <= match_d;
            prescale_q  <= prescale_d;
            compare_q   <= compare_d;
            count_q     <= count_d;
            pcnt_q      <= pcnt_d;
            irq_pulse_q <= irq_pulse_d;
        end
    end

endmodule

// File: tb/tb_bus_timer.sv
// Self-checking bench for bus_timer: read expectations go through a
// scoreboard queue, pulse/irq levels are checked directly.
module tb_bus_timer;

    localparam logic [15:0] BASE = 16'hFF00;
    localparam logic [1:0]  CTRL = 2'd0, PRE = 2'd1, CMP = 2'd2, CNT = 2'd3;

    logic        clk_bus = 1'b0;
    logic        rst_bus;
    logic [15:0] addr, wdata, rdata;
    logic        write, read, irq, irq_pulse;

    int n_chk  = 0;
    int n_pass = 0;

    logic [15:0] exp_q[$];
    string       tag_q[$];

    bus_timer #(.BASE_ADDR(16'hFF00), .RST_COMPARE(16'hFFFF)) dut (
        .clk_bus   (clk_bus),
        .rst_bus   (rst_bus),
        .addr      (addr),
        .wdata     (wdata),
        .write     (write),
        .read      (read),
        .rdata     (rdata),
        .irq       (irq),
        .irq_pulse (irq_pulse)
    );

    always #5 clk_bus = ~clk_bus;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Write one register; the write is sampled on the posedge after the next negedge.
    task automatic wr(input logic [1:0] off, input logic [15:0] d);
        @(negedge clk_bus);
        addr  = BASE + {14'b0, off};
        wdata = d;
        write = 1'b1;
        @(posedge clk_bus);
        #1;
        write = 1'b0;
        addr  = 16'h0000;
        wdata = 16'h0000;
    endtask

    // Combinational read: push expectation, drive, pop and compare after 1ns.
    task automatic rd(input logic [15:0] a, input logic [15:0] e, input string tag);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        addr = a;
        read = 1'b1;
        #1;
        check(tag_q.pop_front(), rdata, exp_q.pop_front());
        read = 1'b0;
        addr = 16'h0000;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_bus = 1'b1;
        addr = '0; wdata = '0; write = 1'b0; read = 1'b0;
        repeat (2) @(posedge clk_bus);
        #1 rst_bus = 1'b0;

        // Reset state
        @(negedge clk_bus);
        rd(BASE + 16'd0, 16'h0000, "rst_ctrl");
        rd(BASE + 16'd1, 16'h0000, "rst_pre");
        rd(BASE + 16'd2, 16'hFFFF, "rst_cmp");
        rd(BASE + 16'd3, 16'h0000, "rst_cnt");
        check("rst_irq", {15'b0, irq}, 16'h0000);
        @(negedge clk_bus);
        rd(BASE + 16'd4, 16'h0000, "unsel_read");
        check("rst_pulse", {15'b0, irq_pulse}, 16'h0000);

        // Auto-reload run, CTRL written at E0
        wr(PRE, 16'd3);
        wr(CMP, 16'd4);
        wr(CTRL, 16'h0007);
        repeat (4) @(posedge clk_bus);
        @(negedge clk_bus);
        rd(BASE + CNT, 16'd1, "auto_cnt_e4");
        repeat (12) @(posedge clk_bus);
        @(negedge clk_bus);
        rd(BASE + CNT, 16'd4, "auto_cnt_e16");
        repeat (3) @(posedge clk_bus);
        @(negedge clk_bus);
        check("auto_pulse_e19", {15'b0, irq_pulse}, 16'h0000);
        check("auto_irq_e19", {15'b0, irq}, 16'h0000);
        @(posedge clk_bus);
        @(negedge clk_bus);
        rd(BASE + CTRL, 16'h0107, "auto_ctrl_e20");
        rd(BASE + CNT, 16'h0000, "auto_cnt_e20");
        check("auto_irq_e20", {15'b0, irq}, 16'h0001);
        check("auto_pulse_e20", {15'b0, irq_pulse}, 16'h0001);
        @(posedge clk_bus);
        @(negedge clk_bus);
        check("auto_pulse_e21", {15'b0, irq_pulse}, 16'h0000);
        repeat (18) @(posedge clk_bus);
        @(negedge clk_bus);
        check("auto_pulse_e39", {15'b0, irq_pulse}, 16'h0000);
        @(posedge clk_bus);
        @(negedge clk_bus);
        check("auto_pulse_e40", {15'b0, irq_pulse}, 16'h0001);
        rd(BASE + CNT, 16'h0000, "auto_cnt_e40");

        // W1C of MATCH away from a match edge
        wr(CTRL, 16'h0105);
        @(negedge clk_bus);
        rd(BASE + CTRL, 16'h0005, "w1c_ctrl");
        check("w1c_irq", {15'b0, irq}, 16'h0000);

        // W1C aligned with a match edge: set wins
        wr(CTRL, 16'h0100);
        wr(CNT, 16'h0000);
        wr(PRE, 16'h0000);
        wr(CMP, 16'd2);
        wr(CTRL, 16'h0007);
        repeat (3) @(posedge clk_bus);
        @(negedge clk_bus);
        rd(BASE + CTRL, 16'h0107, "align_first_match");
        repeat (2) @(posedge clk_bus);
        wr(CTRL, 16'h0107);
        rd(BASE + CTRL, 16'h0107, "align_w1c_ctrl");
        check("align_irq", {15'b0, irq}, 16'h0001);
        check("align_pulse", {15'b0, irq_pulse}, 16'h0001);

        // One-shot
        wr(CTRL, 16'h0100);
        wr(CNT, 16'h0000);
        wr(CMP, 16'd2);
        wr(CTRL, 16'h0001);
        repeat (2) @(posedge clk_bus);
        @(negedge clk_bus);
        rd(BASE + CNT, 16'd2, "os_cnt_g2");
        rd(BASE + CTRL, 16'h0001, "os_ctrl_g2");
        @(posedge clk_bus);
        @(negedge clk_bus);
        rd(BASE + CTRL, 16'h0100, "os_ctrl_g3");
        rd(BASE + CNT, 16'h0000, "os_cnt_g3");
        repeat (10) @(posedge clk_bus);
        @(negedge clk_bus);
        rd(BASE + CNT, 16'h0000, "os_cnt_hold");
        check("os_irq", {15'b0, irq}, 16'h0000);

        // COUNT write beats a tick
        wr(CTRL, 16'h0100);
        wr(CNT, 16'h0000);
        wr(CMP, 16'd100);
        wr(CTRL, 16'h0003);
        repeat (3) @(posedge clk_bus);
        wr(CNT, 16'h0050);
        @(negedge clk_bus);
        rd(BASE + CNT, 16'h0050, "cntwr_load");
        @(posedge clk_bus);
        @(negedge clk_bus);
        rd(BASE + CNT, 16'h0051, "cntwr_next");

        // Reset mid-operation with a concurrent CTRL write
        wr(CTRL, 16'h0100);
        wr(CNT, 16'h0000);
        wr(CMP, 16'd5);
        wr(CTRL, 16'h0007);
        repeat (9) @(posedge clk_bus);
        @(negedge clk_bus);
        rd(BASE + CNT, 16'd3, "mid_cnt");
        check("mid_irq", {15'b0, irq}, 16'h0001);
        rst_bus = 1'b1;
        addr    = BASE + {14'b0, CTRL};
        wdata   = 16'h0007;
        write   = 1'b1;
        @(posedge clk_bus);
        #1;
        rst_bus = 1'b0;
        write   = 1'b0;
        addr    = 16'h0000;
        wdata   = 16'h0000;
        check("mrst_irq", {15'b0, irq}, 16'h0000);
        @(negedge clk_bus);
        rd(BASE + 16'd0, 16'h0000, "mrst_ctrl");
        rd(BASE + 16'd1, 16'h0000, "mrst_pre");
        rd(BASE + 16'd2, 16'hFFFF, "mrst_cmp");
        rd(BASE + 16'd3, 16'h0000, "mrst_cnt");
        @(posedge clk_bus);
        @(negedge clk_bus);
        rd(BASE + 16'd3, 16'h0000, "mrst_cnt_hold");
        check("mrst_pulse", {15'b0, irq_pulse}, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
